io_serial_tx: RTL
=================

Name: io_serial_tx

Overview:
- Output-side peripheral for the CPU's I/O block.
- Sits on one CPU output port (byte plus write strobe) and shifts each written byte out as an asynchronous 8N1 serial frame.
- Buffers bytes in a small FIFO so the program can issue back-to-back port writes.
- Returns a status nibble that the CPU reads back through an input port (e-side), closing the loop of the port interface.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..255.
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset=0 clears the block on the next rising clk edge).
- wr  in  1  one-cycle write strobe from the CPU output-register write enable.
- data  in  8  byte from the CPU output port; sampled when wr=1.
- clr  in  1  one-cycle strobe; clears the sticky overflow flag.
- tx  out  1  serial line; idle high.
- status  out  4  to a CPU input port: bit0 full, bit1 empty, bit2 busy, bit3 overflow.
- level  out  5  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (reset=0 at a clk edge):
  - tx=1; FIFO emptied (level=0).
  - status=4'b0010 (empty=1, others 0); FSM to IDLE; bit and baud counters cleared.
  - Reset mid-frame aborts the frame; tx returns high on that same edge.
- FIFO write:
  - On an edge with wr=1, the byte is pushed if full=0 as evaluated before that edge.
  - If full=1, the byte is dropped, overflow is set, and FIFO contents are unchanged.
  - A pop on the same edge does not make room for a write while full.
- FIFO pop:
  - Occurs only on the IDLE->START transition or the STOP->START transition.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves level unchanged.
  - On an empty FIFO, push and pop cannot coincide: a pop requires empty=0.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- status flags:
  - full = (level==FIFO_DEPTH); empty = (level==0); busy = (FSM != IDLE).
  - overflow is sticky until the clr edge. If clr and an overflowing write coincide, overflow stays 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If empty=0, pop the head into the shift register, then go to START with tx=0.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shift[0].
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. The shift register shifts right on each bit boundary. A 3-bit counter goes 0..7; after bit 7, go to STOP with tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if empty=0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Latency: wr at edge t with an idle block and empty FIFO gives:
  - empty=0 after edge t;
  - pop and tx=0 at edge t+1;
  - start bit spanning edges t+1..t+1+CLKS_PER_BIT.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads to 0 at each bit boundary, and is held at 0 in IDLE.
- tx is driven from a register (glitch-free).
- wr during transmission never disturbs the frame in progress.

Test Plan:
- Single byte, CLKS_PER_BIT=4: reset low 2 cycles, then wr with data=8'hA5.
  - tx pattern per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first A5, stop).
  - busy=1 for 40 cycles, then status=4'b0010.
- Back-to-back: write 8'h00 and 8'hFF on consecutive cycles.
  - Two frames with no idle cycle between the stop bit and the second start bit.
  - level goes 1,1 (push+pop),1, then 0 at the second pop.
- Overflow, FIFO_DEPTH=4: 6 consecutive writes 8'h01..8'h06.
  - The first byte is popped at edge t+1, so 01..05 are accepted and 06 is dropped.
  - full=1 and overflow=1; transmitted sequence 01,02,03,04,05.
  - clr pulse -> overflow=0 while full persists.
- Full boundary with simultaneous pop:
  - Hold FIFO full and issue wr exactly on the STOP->START pop edge.
  - Byte is dropped, overflow=1, level=FIFO_DEPTH-1 after the edge.
- Reset mid-frame: reset=0 during DATA bit 3 with 2 bytes queued.
  - Next edge: tx=1, level=0, status=4'b0010.
  - Nothing transmitted afterwards until a new write.
- Reset priority: reset=0 coinciding with wr=1 -> byte not stored, level=0.

Source files
------------

// File: rtl/io_serial_tx.sv
// 8N1 serial transmitter fed by a small byte FIFO from a CPU output port.
// Status nibble {overflow, busy, empty, full} is read back through a CPU input port.
module io_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] data,
  input  logic       clr,
  output logic       tx,
  output logic [3:0] status,
  output logic [4:0] level
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  BaudLast = 8'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  DepthLvl = 5'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [4:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       baud_end;
  logic [7:0] head;

  assign full     = (count_q == DepthLvl);
  assign empty    = (count_q == 5'd0);
  // Full is judged before the edge, so a same-edge pop never makes room.
  assign push     = wr & ~full;
  assign baud_end = (baud_q == BaudLast);
  assign head     = mem_q[rptr_q];

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        baud_d = 8'd0;
        bit_d  = 3'd0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = 8'd0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = 8'd0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = 8'd0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = 8'd0;
        bit_d   = 3'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    wptr_d  = push ? (wptr_q + PtrOne) : wptr_q;
    rptr_d  = pop ? (rptr_q + PtrOne) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr && full) begin
      ovf_d = 1'b1;
    end else if (clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      baud_q  <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wptr_q] <= data;
    end
  end

  assign tx     = tx_q;
  assign status = {ovf_q, (state_q != StIdle), empty, full};
  assign level  = count_q;

endmodule
